fp_operand_loader: RTL and testbench

- Upstream feeder for the single-precision floating-point multiplier unit.
- Accepts operands as a byte stream over a valid/ready handshake, MSB first: 4 bytes of A, then 4 bytes of B.
- Commits both words to stable registers that drive the multiplier's dataA/dataB, waits a configurable settle time, then captures dataR.
- Presents the captured product on a valid/ready output. Sits between the board/host byte interface and multiplierunit at the top level.

---
 rtl/fp_mult_pkg.sv | 19 +
 rtl/fp_operand_loader_if.sv | 26 ++
 rtl/fp_operand_loader.sv | 111 +++++++++++
 tb/tb_fp_operand_loader.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_mult_pkg.sv
// rtl/fp_mult_pkg.sv - shared types and widths for the fp multiplier feeder path
package fp_mult_pkg;

    localparam int WORD_W = 32;

    // Wide enough for any byte count that divides a word (down to 1-bit transfers).
    localparam int BCNT_W = $clog2(WORD_W);

    // Settle counter holds RESULT_LAT-1, RESULT_LAT in 1..15.
    localparam int WAIT_W = 4;

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        WAIT   = 2'd2,
        HOLD   = 2'd3
    } loader_state_t;

endpackage

// File: rtl/fp_operand_loader_if.sv
// rtl/fp_operand_loader_if.sv - byte-in / product-out handshake bundle for the operand loader
interface fp_operand_loader_if #(
    parameter int BYTE_W = 8
);
    import fp_mult_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [BYTE_W-1:0] in_byte;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_result;

    // Host side: pushes operand bytes, takes products.
    modport master (
        output in_valid, in_byte, out_ready,
        input  in_ready, out_valid, out_result
    );

    // Loader side.
    modport slave (
        input  in_valid, in_byte, out_ready,
        output in_ready, out_valid, out_result
    );

endinterface

// File: rtl/fp_operand_loader.sv
// rtl/fp_operand_loader.sv - serial operand loader and result capture for the fp multiplier
module fp_operand_loader
    import fp_mult_pkg::*;
#(
    parameter int BYTE_W     = 8,
    parameter int NBYTES     = 4,
    parameter int RESULT_LAT = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    fp_operand_loader_if.slave  bus,
    output logic [WORD_W-1:0]   dataA,
    output logic [WORD_W-1:0]   dataB,
    input  logic [WORD_W-1:0]   dataR,
    output logic                busy
);

    loader_state_t     r_state;
    logic [BCNT_W-1:0] r_byte_cnt;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [WORD_W-1:0] r_stage_a;
    logic [WORD_W-1:0] r_stage_b;
    logic [WORD_W-1:0] r_data_a;
    logic [WORD_W-1:0] r_data_b;
    logic [WORD_W-1:0] r_out_result;
    logic              r_out_valid;

    logic              w_load_state;
    logic              w_accept;
    logic              w_last;
    logic [WORD_W-1:0] w_byte_ext;

    assign w_load_state = (r_state == LOAD_A) || (r_state == LOAD_B);
    // Reset and flush both mask acceptance so an abort never swallows a byte.
    assign bus.in_ready = w_load_state && !reset && !flush;
    assign w_accept     = bus.in_valid && bus.in_ready;
    assign w_last       = (r_byte_cnt == BCNT_W'(NBYTES - 1));
    assign w_byte_ext   = WORD_W'(bus.in_byte);

    assign dataA          = r_data_a;
    assign dataB          = r_data_b;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_result = r_out_result;
    assign busy           = !((r_state == LOAD_A) && (r_byte_cnt == '0));

    // Load/commit/settle/hold sequencer; multiplier-facing registers move only at commit and capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= LOAD_A;
            r_byte_cnt   <= '0;
            r_wait_cnt   <= '0;
            r_stage_a    <= '0;
            r_stage_b    <= '0;
            r_data_a     <= '0;
            r_data_b     <= '0;
            r_out_result <= '0;
            r_out_valid  <= 1'b0;
        end else begin
            case (r_state)
                LOAD_A: begin
                    if (flush) begin
                        r_byte_cnt <= '0;
                        r_state    <= LOAD_A;
                    end else if (w_accept) begin
                        r_stage_a  <= (r_stage_a << BYTE_W) | w_byte_ext;
                        r_byte_cnt <= w_last ? '0 : r_byte_cnt + BCNT_W'(1);
                        if (w_last) begin
                            r_state <= LOAD_B;
                        end
                    end
                end
                LOAD_B: begin
                    if (flush) begin
                        r_byte_cnt <= '0;
                        r_state    <= LOAD_A;
                    end else if (w_accept) begin
                        r_stage_b  <= (r_stage_b << BYTE_W) | w_byte_ext;
                        r_byte_cnt <= w_last ? '0 : r_byte_cnt + BCNT_W'(1);
                        if (w_last) begin
                            // Both operands land on the multiplier in the same cycle.
                            r_data_a   <= r_stage_a;
                            r_data_b   <= (r_stage_b << BYTE_W) | w_byte_ext;
                            r_wait_cnt <= WAIT_W'(RESULT_LAT - 1);
                            r_state    <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (r_wait_cnt == '0) begin
                        r_out_result <= dataR;
                        r_out_valid  <= 1'b1;
                        r_state      <= HOLD;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - WAIT_W'(1);
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= LOAD_A;
                    end
                end
                default: begin
                    r_state <= LOAD_A;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_operand_loader.sv
// tb/tb_fp_operand_loader.sv - randomized self-checking bench for fp_operand_loader
module tb_fp_operand_loader;
    import fp_mult_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, flush, in_valid, out_ready, sel;
    logic [7:0]  in_byte;
    logic [31:0] da1, db1, dr1, da3, db3, dr3;
    logic        busy1, busy3;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          acc_cyc;
    logic [31:0] last_a [2];
    logic [31:0] last_b [2];

    fp_operand_loader_if #(.BYTE_W(8)) bus1 ();
    fp_operand_loader_if #(.BYTE_W(8)) bus3 ();

    // sel picks which loader (0: RESULT_LAT=1, 1: RESULT_LAT=3) sees in_valid.
    assign bus1.in_valid  = in_valid & ~sel;
    assign bus3.in_valid  = in_valid & sel;
    assign bus1.in_byte   = in_byte;
    assign bus3.in_byte   = in_byte;
    assign bus1.out_ready = out_ready;
    assign bus3.out_ready = out_ready;

    // Multiplier stand-in: exact for normal operands whose product stays normal (truncating).
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        int          e;
        logic [47:0] p;
        s = a[31] ^ b[31];
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'd0};
        p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p[47]) return {s, 8'(e + 1), p[46:24]};
        return {s, 8'(e), p[45:23]};
    endfunction

    assign dr1 = fmul(da1, db1);
    assign dr3 = fmul(da3, db3);

    fp_operand_loader #(.BYTE_W(8), .NBYTES(4), .RESULT_LAT(1)) u_lat1 (
        .clk(clk), .reset(reset), .flush(flush), .bus(bus1.slave),
        .dataA(da1), .dataB(db1), .dataR(dr1), .busy(busy1)
    );

    fp_operand_loader #(.BYTE_W(8), .NBYTES(4), .RESULT_LAT(3)) u_lat3 (
        .clk(clk), .reset(reset), .flush(flush), .bus(bus3.slave),
        .dataA(da3), .dataB(db3), .dataR(dr3), .busy(busy3)
    );

    logic        o_in_ready, o_out_valid, o_busy;
    logic [31:0] o_result, o_da, o_db;
    assign o_in_ready  = sel ? bus3.in_ready   : bus1.in_ready;
    assign o_out_valid = sel ? bus3.out_valid  : bus1.out_valid;
    assign o_result    = sel ? bus3.out_result : bus1.out_result;
    assign o_da        = sel ? da3 : da1;
    assign o_db        = sel ? db3 : db1;
    assign o_busy      = sel ? busy3 : busy1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Presents one byte and returns at the negedge after the edge that took it.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        in_byte  = b;
        in_valid = 1'b1;
        #1;
        while (!o_in_ready && n < 50) begin
            step();
            #1;
            n++;
        end
        if (n >= 50) check("in_ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        acc_cyc  = cyc;
    endtask

    task automatic send_word(input logic [31:0] w, input int maxgap);
        logic [31:0] rest;
        rest = w;
        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(0, maxgap)) step();
            send_byte(8'(rest / 32'h0100_0000));
            rest = rest * 256;
        end
    endtask

    // Full transaction: load, check commit, latency and product, optional backpressure, release.
    task automatic run_txn(input logic [31:0] a, input logic [31:0] b, input int maxgap, input int hold_cyc);
        int k, n, lat;
        logic [31:0] exp_r;
        lat   = sel ? 3 : 1;
        exp_r = fmul(a, b);
        out_ready = (hold_cyc == 0);
        send_word(a, maxgap);
        check("dataA_before_commit", o_da, last_a[sel]);
        send_word(b, maxgap);
        k = acc_cyc;
        check("dataA_commit", o_da, a);
        check("dataB_commit", o_db, b);
        last_a[sel] = a;
        last_b[sel] = b;
        n = 0;
        #1;
        while (!o_out_valid && n < 40) begin
            step();
            #1;
            n++;
        end
        check("out_valid_seen", 32'(o_out_valid), 32'd1);
        check("latency", 32'(cyc - k), 32'(lat));
        check("result", o_result, exp_r);
        for (int i = 0; i < hold_cyc; i++) begin
            in_valid = 1'b1;
            in_byte  = 8'($urandom);
            #1;
            check("hold_valid", 32'(o_out_valid), 32'd1);
            check("hold_result", o_result, exp_r);
            check("hold_in_ready", 32'(o_in_ready), 32'd0);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        #1;
        check("released_valid", 32'(o_out_valid), 32'd0);
        check("released_busy", 32'(o_busy), 32'd0);
        check("released_in_ready", 32'(o_in_ready), 32'd1);
    endtask

    function automatic logic [31:0] rand_float();
        return {1'($urandom), 8'($urandom_range(100, 150)), 23'($urandom)};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_byte = 8'd0;
        out_ready = 1'b1; sel = 1'b0;
        last_a[0] = 0; last_b[0] = 0; last_a[1] = 0; last_b[1] = 0;
        @(negedge clk);
        in_valid = 1'b1;
        #1;
        check("reset_in_ready1", 32'(bus1.in_ready), 32'd0);
        check("reset_in_ready3", 32'(bus3.in_ready), 32'd0);
        step();
        step();
        in_valid = 1'b0;
        reset    = 1'b0;
        #1;
        check("reset_dataA", da1, 32'd0);
        check("reset_dataB", db1, 32'd0);
        check("reset_result", bus1.out_result, 32'd0);
        check("reset_out_valid", 32'(bus1.out_valid), 32'd0);
        check("reset_busy", 32'(busy1), 32'd0);
        check("idle_in_ready", 32'(bus1.in_ready), 32'd1);

        // 3.0 x 2.0 and -1.5 x 4.0 on the single-cycle loader.
        run_txn(32'h4040_0000, 32'h4000_0000, 0, 0);
        check("basic_const", bus1.out_result, 32'h40C0_0000);
        run_txn(32'hBFC0_0000, 32'h4080_0000, 0, 6);
        check("bp_const", bus1.out_result, 32'hC0C0_0000);

        // Flush over a partial A with a byte on offer.
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        flush = 1'b1; in_valid = 1'b1; in_byte = 8'h44;
        #1;
        check("flush_in_ready", 32'(o_in_ready), 32'd0);
        step();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        check("flush_busy", 32'(o_busy), 32'd0);
        check("flush_dataA", o_da, 32'hBFC0_0000);
        check("flush_dataB", o_db, 32'h4080_0000);
        run_txn(32'h4040_0000, 32'h4000_0000, 0, 0);
        check("flush_const", o_result, 32'h40C0_0000);

        // Reset one cycle after commit on the 3-cycle loader.
        sel = 1'b1;
        send_word(32'h4040_0000, 0);
        send_word(32'h4000_0000, 0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        last_a[0] = 0; last_b[0] = 0; last_a[1] = 0; last_b[1] = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            check("rst_wait_valid", 32'(o_out_valid), 32'd0);
            step();
        end
        check("rst_wait_dataA", o_da, 32'd0);
        check("rst_wait_dataB", o_db, 32'd0);
        check("rst_wait_result", o_result, 32'd0);
        check("rst_wait_busy", 32'(o_busy), 32'd0);

        // 2.0 x 2.0 with idle gaps.
        run_txn(32'h4000_0000, 32'h4000_0000, 4, 0);
        check("gap_const", o_result, 32'h4080_0000);

        // Random mix, with occasional aborted partial loads.
        for (int t = 0; t < 16; t++) begin
            sel = 1'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 7)) send_byte(8'($urandom));
                flush = 1'b1;
                step();
                flush = 1'b0;
                #1;
                check("rnd_flush_busy", 32'(o_busy), 32'd0);
                check("rnd_flush_dataA", o_da, last_a[sel]);
                check("rnd_flush_dataB", o_db, last_b[sel]);
            end
            run_txn(rand_float(), rand_float(), $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
